// File: rtl/sysid_check_arbiter_if.sv
// Host-side Avalon-MM read-only port of the system-ID check arbiter.
// The master modport is the host; the slave modport is the arbiter.
interface sysid_check_arbiter_if;
    logic        host_read;
    logic        host_address;
    logic        host_waitrequest;
    logic [31:0] host_readdata;
    logic        host_readdatavalid;

    modport master (
        output host_read,
        output host_address,
        input  host_waitrequest,
        input  host_readdata,
        input  host_readdatavalid
    );

    modport slave (
        input  host_read,
        input  host_address,
        output host_waitrequest,
        output host_readdata,
        output host_readdatavalid
    );
endinterface

// File: rtl/sysid_check_arbiter.sv
// Owns the system-ID slave: checks ID and timestamp after reset or on request,
// then shares the slave with a host read port. The check always has priority.
module sysid_check_arbiter #(
    parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS  = 32'h5801_2555,
    parameter bit          CHECK_TS     = 1'b1,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 sid_address,
    input  logic [31:0]          sid_readdata,
    sysid_check_arbiter_if.slave host,
    input  logic                 check_start,
    output logic                 check_done,
    output logic                 id_ok,
    output logic                 ts_ok,
    output logic                 check_pass,
    output logic [31:0]          id_value,
    output logic [31:0]          ts_value
);

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    typedef enum logic [1:0] {
        BOOT_ID,
        BOOT_TS,
        IDLE,
        HOST
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic [2:0]  cnt_next;
    logic        pend;
    logic        host_addr_q;
    logic        sample;
    logic        start_check;
    logic        accept;
    logic        waitrequest;
    logic        readdatavalid;
    logic [31:0] readdata;
    logic        ts_match;

    assign sample   = (cnt == 3'd0);
    assign ts_match = CHECK_TS ? (sid_readdata == EXPECTED_TS) : 1'b1;

    assign host.host_waitrequest   = waitrequest;
    assign host.host_readdata      = readdata;
    assign host.host_readdatavalid = readdatavalid;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next  = state;
        cnt_next    = cnt;
        start_check = 1'b0;
        accept      = 1'b0;
        sid_address = 1'b0;
        waitrequest = 1'b1;

        case (state)
            BOOT_ID: begin
                if (sample) begin
                    state_next = BOOT_TS;
                    cnt_next   = LAT;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            BOOT_TS: begin
                sid_address = 1'b1;
                if (sample) state_next = IDLE;
                else        cnt_next   = cnt - 3'd1;
            end
            IDLE: begin
                // A pending or fresh check request beats a host read in the same cycle.
                if (check_start || pend) begin
                    start_check = 1'b1;
                    state_next  = BOOT_ID;
                    cnt_next    = LAT;
                end else if (host.host_read) begin
                    accept      = 1'b1;
                    waitrequest = 1'b0;
                    state_next  = HOST;
                    cnt_next    = LAT;
                end
            end
            HOST: begin
                sid_address = host_addr_q;
                if (sample) state_next = IDLE;
                else        cnt_next   = cnt - 3'd1;
            end
            default: state_next = BOOT_ID;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= BOOT_ID;
            cnt           <= LAT;
            pend          <= 1'b0;
            host_addr_q   <= 1'b0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
            check_done    <= 1'b0;
            id_ok         <= 1'b0;
            ts_ok         <= 1'b0;
            check_pass    <= 1'b0;
            id_value      <= '0;
            ts_value      <= '0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            readdatavalid <= 1'b0;

            if (accept) host_addr_q <= host.host_address;

            // A request outside IDLE is remembered until the next IDLE cycle.
            if (start_check) begin
                pend       <= 1'b0;
                check_done <= 1'b0;
                id_ok      <= 1'b0;
                ts_ok      <= 1'b0;
                check_pass <= 1'b0;
            end else if (check_start) begin
                pend <= 1'b1;
            end

            if (sample) begin
                case (state)
                    BOOT_ID: begin
                        id_value <= sid_readdata;
                        id_ok    <= (sid_readdata == EXPECTED_ID);
                    end
                    BOOT_TS: begin
                        ts_value   <= sid_readdata;
                        ts_ok      <= ts_match;
                        check_done <= 1'b1;
                        check_pass <= id_ok & ts_match;
                    end
                    HOST: begin
                        readdata      <= sid_readdata;
                        readdatavalid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sysid_check_arbiter.sv
// Directed bench for sysid_check_arbiter: boot check, host reads, check priority,
// deferred recheck and reset abort, all with L=1 and hand-computed cycle timing.
module tb_sysid_check_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        check_start;
    logic [31:0] id_word;
    logic [31:0] ts_word;

    logic        sid_address,  sid_address_n;
    logic [31:0] sid_readdata, sid_readdata_n;
    logic        check_done, id_ok, ts_ok, check_pass;
    logic        check_done_n, id_ok_n, ts_ok_n, check_pass_n;
    logic [31:0] id_value, ts_value, id_value_n, ts_value_n;

    int assertions = 0;
    int failures   = 0;

    always #5 clock = ~clock;

    sysid_check_arbiter_if host_if ();
    sysid_check_arbiter_if host_if_n ();

    // Combinational sysid slave model, one per DUT.
    assign sid_readdata   = sid_address   ? ts_word : id_word;
    assign sid_readdata_n = sid_address_n ? ts_word : id_word;

    sysid_check_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .sid_address  (sid_address),
        .sid_readdata (sid_readdata),
        .host         (host_if),
        .check_start  (check_start),
        .check_done   (check_done),
        .id_ok        (id_ok),
        .ts_ok        (ts_ok),
        .check_pass   (check_pass),
        .id_value     (id_value),
        .ts_value     (ts_value)
    );

    sysid_check_arbiter #(.CHECK_TS(1'b0)) dut_n (
        .clock        (clock),
        .reset        (reset),
        .sid_address  (sid_address_n),
        .sid_readdata (sid_readdata_n),
        .host         (host_if_n),
        .check_start  (check_start),
        .check_done   (check_done_n),
        .id_ok        (id_ok_n),
        .ts_ok        (ts_ok_n),
        .check_pass   (check_pass_n),
        .id_value     (id_value_n),
        .ts_value     (ts_value_n)
    );

    task automatic cycle();
        @(negedge clock);
        #1;
    endtask

    // Leaves the bench at cycle 0: reset just released, registers still at reset values.
    task automatic reset_dut();
        @(negedge clock);
        reset               = 1'b1;
        check_start         = 1'b0;
        host_if.host_read   = 1'b0;
        host_if.host_address = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        id_word = 32'h0000_0000;
        ts_word = 32'h5801_2555;
        reset_dut();
        assertions++; if (check_done !== 1'b0) begin failures++; $display("FAIL reset_check_done: got %b want 0", check_done); end
        assertions++; if (check_pass !== 1'b0) begin failures++; $display("FAIL reset_check_pass: got %b want 0", check_pass); end
        assertions++; if (host_if.host_readdatavalid !== 1'b0) begin failures++; $display("FAIL reset_rdv: got %b want 0", host_if.host_readdatavalid); end
        assertions++; if (host_if.host_readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata: got %h want 0", host_if.host_readdata); end
        assertions++; if (id_value !== 32'h0 || ts_value !== 32'h0) begin failures++; $display("FAIL reset_values: got %h/%h want 0/0", id_value, ts_value); end
        // Host holds a read during boot; it must not be accepted before cycle 4.
        host_if.host_read    = 1'b1;
        host_if.host_address = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) cycle();
            #1;
            assertions++; if (host_if.host_waitrequest !== 1'b1) begin failures++; $display("FAIL boot_waitreq_c%0d: got %b want 1", c, host_if.host_waitrequest); end
            assertions++; if (check_done !== 1'b0) begin failures++; $display("FAIL boot_done_early_c%0d: got %b want 0", c, check_done); end
        end
        cycle();
        assertions++; if (check_done !== 1'b1) begin failures++; $display("FAIL boot_done_c4: got %b want 1", check_done); end
        assertions++; if (check_pass !== 1'b1) begin failures++; $display("FAIL boot_pass_c4: got %b want 1", check_pass); end
        assertions++; if (id_ok !== 1'b1 || ts_ok !== 1'b1) begin failures++; $display("FAIL boot_ok_c4: got %b%b want 11", id_ok, ts_ok); end
        assertions++; if (id_value !== 32'h0) begin failures++; $display("FAIL boot_id_value: got %h want 00000000", id_value); end
        assertions++; if (ts_value !== 32'h5801_2555) begin failures++; $display("FAIL boot_ts_value: got %h want 58012555", ts_value); end
        assertions++; if (host_if.host_waitrequest !== 1'b0) begin failures++; $display("FAIL boot_accept_c4: got %b want 0", host_if.host_waitrequest); end
        cycle();
        host_if.host_read = 1'b0;
        cycle();
        cycle();
        assertions++; if (host_if.host_readdatavalid !== 1'b1 || host_if.host_readdata !== 32'h5801_2555) begin failures++; $display("FAIL boot_read_c7: got %b/%h want 1/58012555", host_if.host_readdatavalid, host_if.host_readdata); end
    endtask

    task automatic test_bad_words();
        id_word = 32'h0000_0001;
        ts_word = 32'h5801_2555;
        reset_dut();
        repeat (4) cycle();
        assertions++; if (check_done !== 1'b1) begin failures++; $display("FAIL badid_done: got %b want 1", check_done); end
        assertions++; if (id_ok !== 1'b0 || ts_ok !== 1'b1) begin failures++; $display("FAIL badid_ok: got %b%b want 01", id_ok, ts_ok); end
        assertions++; if (check_pass !== 1'b0 || check_pass_n !== 1'b0) begin failures++; $display("FAIL badid_pass: got %b/%b want 0/0", check_pass, check_pass_n); end
        assertions++; if (id_value !== 32'h1) begin failures++; $display("FAIL badid_value: got %h want 00000001", id_value); end

        id_word = 32'h0000_0000;
        ts_word = 32'hdead_beef;
        reset_dut();
        repeat (4) cycle();
        assertions++; if (check_done_n !== 1'b1 || ts_ok_n !== 1'b1) begin failures++; $display("FAIL nots_done_ok: got %b%b want 11", check_done_n, ts_ok_n); end
        assertions++; if (check_pass_n !== 1'b1) begin failures++; $display("FAIL nots_pass: got %b want 1", check_pass_n); end
        assertions++; if (ts_value_n !== 32'hdead_beef) begin failures++; $display("FAIL nots_ts_value: got %h want deadbeef", ts_value_n); end
        assertions++; if (ts_ok !== 1'b0 || check_pass !== 1'b0) begin failures++; $display("FAIL badts_checked: got %b%b want 00", ts_ok, check_pass); end
        ts_word = 32'h5801_2555;
    endtask

    task automatic test_host_read();
        reset_dut();
        repeat (4) cycle();
        host_if.host_read    = 1'b1;
        host_if.host_address = 1'b1;
        #1;
        assertions++; if (host_if.host_waitrequest !== 1'b0) begin failures++; $display("FAIL hr_accept: got %b want 0", host_if.host_waitrequest); end
        cycle();
        host_if.host_read = 1'b0;
        #1;
        assertions++; if (host_if.host_waitrequest !== 1'b1 || sid_address !== 1'b1) begin failures++; $display("FAIL hr_t1: got wr=%b addr=%b want 1/1", host_if.host_waitrequest, sid_address); end
        assertions++; if (host_if.host_readdatavalid !== 1'b0) begin failures++; $display("FAIL hr_rdv_t1: got %b want 0", host_if.host_readdatavalid); end
        cycle();
        assertions++; if (host_if.host_readdatavalid !== 1'b0) begin failures++; $display("FAIL hr_rdv_t2: got %b want 0", host_if.host_readdatavalid); end
        cycle();
        assertions++; if (host_if.host_readdatavalid !== 1'b1 || host_if.host_readdata !== 32'h5801_2555) begin failures++; $display("FAIL hr_t3: got %b/%h want 1/58012555", host_if.host_readdatavalid, host_if.host_readdata); end
    endtask

    // Entered at an IDLE cycle.
    task automatic test_back_to_back();
        host_if.host_read    = 1'b1;
        host_if.host_address = 1'b0;
        #1;
        assertions++; if (host_if.host_waitrequest !== 1'b0) begin failures++; $display("FAIL b2b_accept0: got %b want 0", host_if.host_waitrequest); end
        cycle();
        host_if.host_address = 1'b1;
        #1;
        assertions++; if (host_if.host_waitrequest !== 1'b1 || sid_address !== 1'b0) begin failures++; $display("FAIL b2b_t1: got wr=%b addr=%b want 1/0", host_if.host_waitrequest, sid_address); end
        cycle();
        assertions++; if (host_if.host_waitrequest !== 1'b1) begin failures++; $display("FAIL b2b_t2_wr: got %b want 1", host_if.host_waitrequest); end
        cycle();
        assertions++; if (host_if.host_readdatavalid !== 1'b1 || host_if.host_readdata !== 32'h0) begin failures++; $display("FAIL b2b_t3_data: got %b/%h want 1/00000000", host_if.host_readdatavalid, host_if.host_readdata); end
        assertions++; if (host_if.host_waitrequest !== 1'b0) begin failures++; $display("FAIL b2b_accept1: got %b want 0", host_if.host_waitrequest); end
        cycle();
        host_if.host_read = 1'b0;
        #1;
        assertions++; if (host_if.host_readdatavalid !== 1'b0 || host_if.host_readdata !== 32'h0) begin failures++; $display("FAIL b2b_t4_hold: got %b/%h want 0/00000000", host_if.host_readdatavalid, host_if.host_readdata); end
        cycle();
        assertions++; if (host_if.host_readdatavalid !== 1'b0) begin failures++; $display("FAIL b2b_t5_rdv: got %b want 0", host_if.host_readdatavalid); end
        cycle();
        assertions++; if (host_if.host_readdatavalid !== 1'b1 || host_if.host_readdata !== 32'h5801_2555) begin failures++; $display("FAIL b2b_t6_data: got %b/%h want 1/58012555", host_if.host_readdatavalid, host_if.host_readdata); end
    endtask

    // Entered at an IDLE cycle; check_start arrives while the host read is in flight.
    task automatic test_pending_check();
        host_if.host_read    = 1'b1;
        host_if.host_address = 1'b0;
        #1;
        assertions++; if (host_if.host_waitrequest !== 1'b0) begin failures++; $display("FAIL pend_accept: got %b want 0", host_if.host_waitrequest); end
        cycle();
        host_if.host_read = 1'b0;
        check_start       = 1'b1;
        cycle();
        check_start = 1'b0;
        assertions++; if (check_done !== 1'b1) begin failures++; $display("FAIL pend_done_t2: got %b want 1", check_done); end
        cycle();
        assertions++; if (host_if.host_readdatavalid !== 1'b1 || host_if.host_readdata !== 32'h0) begin failures++; $display("FAIL pend_read_t3: got %b/%h want 1/00000000", host_if.host_readdatavalid, host_if.host_readdata); end
        assertions++; if (check_done !== 1'b1) begin failures++; $display("FAIL pend_done_t3: got %b want 1", check_done); end
        // The recheck must actually re-read the slave.
        id_word = 32'h0000_0001;
        for (int t = 4; t < 8; t++) begin
            cycle();
            assertions++; if (check_done !== 1'b0) begin failures++; $display("FAIL pend_done_low_t%0d: got %b want 0", t, check_done); end
        end
        cycle();
        assertions++; if (check_done !== 1'b1) begin failures++; $display("FAIL pend_done_t8: got %b want 1", check_done); end
        assertions++; if (id_ok !== 1'b0 || check_pass !== 1'b0 || id_value !== 32'h1) begin failures++; $display("FAIL pend_result_t8: got ok=%b pass=%b id=%h want 0/0/00000001", id_ok, check_pass, id_value); end
        id_word = 32'h0000_0000;
    endtask

    // Entered at an IDLE cycle; check_start and host_read arrive together.
    task automatic test_check_priority();
        check_start          = 1'b1;
        host_if.host_read    = 1'b1;
        host_if.host_address = 1'b1;
        #1;
        assertions++; if (host_if.host_waitrequest !== 1'b1) begin failures++; $display("FAIL prio_s0_wr: got %b want 1", host_if.host_waitrequest); end
        for (int s = 1; s < 5; s++) begin
            cycle();
            check_start = 1'b0;
            #1;
            assertions++; if (host_if.host_waitrequest !== 1'b1 || check_done !== 1'b0) begin failures++; $display("FAIL prio_s%0d: got wr=%b done=%b want 1/0", s, host_if.host_waitrequest, check_done); end
        end
        cycle();
        assertions++; if (check_done !== 1'b1 || check_pass !== 1'b1) begin failures++; $display("FAIL prio_s5_done: got %b%b want 11", check_done, check_pass); end
        assertions++; if (host_if.host_waitrequest !== 1'b0) begin failures++; $display("FAIL prio_s5_accept: got %b want 0", host_if.host_waitrequest); end
        cycle();
        host_if.host_read = 1'b0;
        cycle();
        assertions++; if (host_if.host_readdatavalid !== 1'b0) begin failures++; $display("FAIL prio_s7_rdv: got %b want 0", host_if.host_readdatavalid); end
        cycle();
        assertions++; if (host_if.host_readdatavalid !== 1'b1 || host_if.host_readdata !== 32'h5801_2555) begin failures++; $display("FAIL prio_s8_data: got %b/%h want 1/58012555", host_if.host_readdatavalid, host_if.host_readdata); end
    endtask

    // Entered at an IDLE cycle; reset lands while a host read is in flight.
    task automatic test_reset_abort();
        ts_word              = 32'h1234_5678;
        host_if.host_read    = 1'b1;
        host_if.host_address = 1'b1;
        #1;
        assertions++; if (host_if.host_waitrequest !== 1'b0) begin failures++; $display("FAIL abort_accept: got %b want 0", host_if.host_waitrequest); end
        cycle();
        host_if.host_read = 1'b0;
        reset             = 1'b1;
        cycle();
        ts_word = 32'h5801_2555;
        assertions++; if (host_if.host_readdatavalid !== 1'b0 || host_if.host_readdata !== 32'h0) begin failures++; $display("FAIL abort_host: got %b/%h want 0/00000000", host_if.host_readdatavalid, host_if.host_readdata); end
        assertions++; if (check_done !== 1'b0 || check_pass !== 1'b0 || id_value !== 32'h0 || ts_value !== 32'h0) begin failures++; $display("FAIL abort_check: got done=%b pass=%b id=%h ts=%h want 0/0/0/0", check_done, check_pass, id_value, ts_value); end
        assertions++; if (host_if.host_waitrequest !== 1'b1) begin failures++; $display("FAIL abort_wr: got %b want 1", host_if.host_waitrequest); end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) cycle();
            assertions++; if (host_if.host_readdatavalid !== 1'b0 || check_done !== 1'b0) begin failures++; $display("FAIL abort_boot_c%0d: got rdv=%b done=%b want 0/0", c, host_if.host_readdatavalid, check_done); end
        end
        cycle();
        assertions++; if (check_done !== 1'b1 || check_pass !== 1'b1 || ts_value !== 32'h5801_2555) begin failures++; $display("FAIL abort_reboot: got done=%b pass=%b ts=%h want 1/1/58012555", check_done, check_pass, ts_value); end
    endtask

    initial begin
        reset                  = 1'b1;
        check_start            = 1'b0;
        id_word                = 32'h0;
        ts_word                = 32'h5801_2555;
        host_if.host_read      = 1'b0;
        host_if.host_address   = 1'b0;
        host_if_n.host_read    = 1'b0;
        host_if_n.host_address = 1'b0;

        test_reset();
        test_bad_words();
        test_host_read();
        test_back_to_back();
        test_pending_check();
        test_check_priority();
        test_reset_abort();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
